// File: rtl/demux_pkg.sv
// Shared lane-count, select types and select decode
// for the registered 1:8 demultiplexer.
package demux_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;
  typedef logic [LANES-1:0] lane_mask_t;

  function automatic lane_mask_t sel_onehot(
    input lane_sel_t s
  );
    return lane_mask_t'(1) << s;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry lane holding buffer: a load always wins,
// otherwise the entry clears when the consumer takes it.
module demux_lane #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         ready_i,
  output logic [N-1:0] data_o,
  output logic         valid_o
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_1to8_buf.sv
// Registered 1:8 demux with per-lane one-entry buffers.
// Optional broadcast port enabled by DEMUX_BCAST_EN.
module demux_1to8_buf
  import demux_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       I,
  input  lane_sel_t          S,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [LANES*N-1:0] O,
  output logic [LANES-1:0]   out_valid,
`ifdef DEMUX_BCAST_EN
  input  logic               bcast,
`endif
  input  logic [LANES-1:0]   out_ready
);

  lane_mask_t blocked;
  lane_mask_t dest;
  lane_mask_t load;
  logic       room;
  logic       xfer;

  // a lane is blocked only if full and not draining now
  assign blocked = out_valid & ~out_ready;

  always_comb begin
    dest = sel_onehot(S);
    room = ~blocked[S];
`ifdef DEMUX_BCAST_EN
    if (bcast) begin
      dest = '1;
      room = ~|blocked;
    end
`endif
  end

  assign in_ready = rst & enable & room;
  assign xfer     = in_valid & in_ready;
  assign load     = {LANES{xfer}} & dest;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(.N(N)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (I),
      .ready_i (out_ready[k]),
      .data_o  (O[k*N +: N]),
      .valid_o (out_valid[k])
    );
  end

endmodule
